// File: rtl/port_ingress_fifo.sv
// -----------------------------------------------------------------------------
// port_ingress_fifo
//
// Per-port ingress buffer placed in front of one switch port. Host packets
// (source, target, data) are checked for legality and stored in a DEPTH-entry
// FIFO. Packets are presented to the switch port in order through a
// show-ahead valid/ready interface. Malformed packets, and packets that arrive
// while the FIFO is full with no pop in that cycle, are dropped. Each drop
// produces a one-cycle drop_pulse one cycle later.
//
// Optional feature macro: INGRESS_DROP_CNT_EN
//   defined   -> drop_cnt port with an 8-bit saturating drop counter
//   undefined -> no drop_cnt port and no counter; all other behaviour is the same
//
// Ports
//   clk         in   clock; all state changes on the rising edge
//   rst         in   synchronous active-high reset
//   in_valid    in   host packet present this cycle (the host sees no backpressure)
//   in_source   in   one-hot source address
//   in_target   in   one-hot target address
//   in_data     in   payload
//   out_valid   out  head packet available (!empty)
//   out_source  out  head source, 0 when empty
//   out_target  out  head target, 0 when empty
//   out_data    out  head payload, 0 when empty
//   out_ready   in   switch port consumes the head this cycle
//   count       out  number of stored packets
//   full        out  count == DEPTH
//   empty       out  count == 0
//   drop_pulse  out  high for the cycle after each drop
//   drop_cnt    out  saturating drop counter (only with INGRESS_DROP_CNT_EN)
// -----------------------------------------------------------------------------
module port_ingress_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [ADDR_WIDTH-1:0]      in_source,
    input  logic [ADDR_WIDTH-1:0]      in_target,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       out_valid,
    output logic [ADDR_WIDTH-1:0]      out_source,
    output logic [ADDR_WIDTH-1:0]      out_target,
    output logic [DATA_WIDTH-1:0]      out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
`ifdef INGRESS_DROP_CNT_EN
    output logic [7:0]                 drop_cnt,
`endif
    output logic                       drop_pulse
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    // True when exactly one bit is set: non-zero, and clearing the lowest
    // set bit leaves nothing.
    function automatic logic is_onehot(input logic [ADDR_WIDTH-1:0] v);
        logic [ADDR_WIDTH-1:0] v_minus_one;
        v_minus_one = v - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        return (v != {ADDR_WIDTH{1'b0}}) && ((v & v_minus_one) == {ADDR_WIDTH{1'b0}});
    endfunction

    // Storage (not reset; validity comes from count)
    logic [ADDR_WIDTH-1:0] src_mem_r  [DEPTH];
    logic [ADDR_WIDTH-1:0] tgt_mem_r  [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_r [DEPTH];

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             drop_pulse_r;

    logic legal_s;
    logic empty_s;
    logic full_s;
    logic pop_s;
    logic push_s;
    logic drop_s;

    // Legality, handshake and push/pop/drop decisions for this cycle
    always_comb begin
        legal_s = 1'b0;
        empty_s = 1'b0;
        full_s  = 1'b0;
        pop_s   = 1'b0;
        push_s  = 1'b0;
        drop_s  = 1'b0;

        legal_s = is_onehot(in_source) && is_onehot(in_target) && (in_target != in_source);
        empty_s = (count_r == CNT_ZERO);
        full_s  = (count_r == CNT_DEPTH);
        // out_ready while empty is ignored
        pop_s   = !empty_s && out_ready;
        // A pop in the same cycle frees the slot a full FIFO needs
        push_s  = in_valid && legal_s && (!full_s || pop_s);
        // Illegal-and-full still counts once: every non-pushed valid is one drop
        drop_s  = in_valid && !push_s;
    end

    // Packet storage write; suppressed during reset so a push in the reset cycle is lost
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            src_mem_r[wr_ptr_r]  <= in_source;
            tgt_mem_r[wr_ptr_r]  <= in_target;
            data_mem_r[wr_ptr_r] <= in_data;
        end
    end

    // Pointers, occupancy count and drop pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= CNT_ZERO;
            drop_pulse_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            drop_pulse_r <= drop_s;
        end
    end

`ifdef INGRESS_DROP_CNT_EN
    logic [7:0] drop_cnt_r;

    // Saturating drop counter; sticks at 255
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_r <= 8'd0;
        end else if (drop_s && (drop_cnt_r != 8'd255)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_r;
`endif

    // Show-ahead head, forced to zero when nothing is stored
    always_comb begin
        out_valid  = 1'b0;
        out_source = {ADDR_WIDTH{1'b0}};
        out_target = {ADDR_WIDTH{1'b0}};
        out_data   = {DATA_WIDTH{1'b0}};
        if (!empty_s) begin
            out_valid  = 1'b1;
            out_source = src_mem_r[rd_ptr_r];
            out_target = tgt_mem_r[rd_ptr_r];
            out_data   = data_mem_r[rd_ptr_r];
        end else begin
            out_valid  = 1'b0;
        end
    end

    assign count      = count_r;
    assign full       = full_s;
    assign empty      = empty_s;
    assign drop_pulse = drop_pulse_r;

endmodule

// File: tb/tb_port_ingress_fifo.sv
// -----------------------------------------------------------------------------
// tb_port_ingress_fifo
//
// Directed self-checking bench for port_ingress_fifo (DEPTH 4, 16-bit data,
// 4-bit one-hot addresses). Inputs are driven 1 ns after the rising edge.
// Outputs are sampled at that same point, well away from the next edge.
// The drop_cnt checks are compiled only when INGRESS_DROP_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_port_ingress_fifo;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_source;
    logic [3:0]  in_target;
    logic [15:0] in_data;
    logic        out_valid;
    logic [3:0]  out_source;
    logic [3:0]  out_target;
    logic [15:0] out_data;
    logic        out_ready;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        drop_pulse;
`ifdef INGRESS_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    port_ingress_fifo #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(4),
        .DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_source(in_source),
        .in_target(in_target),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_source(out_source),
        .out_target(out_target),
        .out_data(out_data),
        .out_ready(out_ready),
        .count(count),
        .full(full),
        .empty(empty),
`ifdef INGRESS_DROP_CNT_EN
        .drop_cnt(drop_cnt),
`endif
        .drop_pulse(drop_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] s, input logic [3:0] t,
                         input logic [15:0] d, input logic rdy);
        in_valid  = v;
        in_source = s;
        in_target = t;
        in_data   = d;
        out_ready = rdy;
    endtask

    logic [3:0]  tgt_tab [4];
    logic [15:0] exp_q [$];
    logic [3:0]  exp_t_q [$];
    int          model_cnt;
    int          pushed;
    int          pulses;
    logic        do_push;
    logic        do_pop;

    initial begin
        tgt_tab[0] = 4'b0010;
        tgt_tab[1] = 4'b0100;
        tgt_tab[2] = 4'b1000;
        tgt_tab[3] = 4'b0010;

        // ---------------- reset ----------------
        rst = 1'b1;
        drive(1'b0, 4'b0000, 4'b0000, 16'h0000, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_out_valid",  {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_source", {28'd0, out_source}, 32'd0);
        check_eq("rst_out_target", {28'd0, out_target}, 32'd0);
        check_eq("rst_out_data",   {16'd0, out_data}, 32'd0);
        check_eq("rst_count",      {29'd0, count}, 32'd0);
        check_eq("rst_full",       {31'd0, full}, 32'd0);
        check_eq("rst_empty",      {31'd0, empty}, 32'd1);
        check_eq("rst_drop_pulse", {31'd0, drop_pulse}, 32'd0);
`ifdef INGRESS_DROP_CNT_EN
        check_eq("rst_drop_cnt",   {24'd0, drop_cnt}, 32'd0);
`endif

        // ---------------- fill ----------------
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'b0001, tgt_tab[i], 16'hA000 + 16'(i), 1'b0);
            tick();
            if (i == 0) begin
                // one-cycle ingress-to-head latency
                check_eq("lat_out_valid", {31'd0, out_valid}, 32'd1);
                check_eq("lat_out_data",  {16'd0, out_data}, 32'h0000A000);
            end
        end
        check_eq("fill_count",  {29'd0, count}, 32'd4);
        check_eq("fill_full",   {31'd0, full}, 32'd1);
        check_eq("fill_head",   {16'd0, out_data}, 32'h0000A000);
        check_eq("fill_src",    {28'd0, out_source}, 32'd1);
        check_eq("fill_tgt",    {28'd0, out_target}, 32'd2);

        // ---------------- full drop ----------------
        drive(1'b1, 4'b0001, 4'b0100, 16'hBEEF, 1'b0);
        tick();
        check_eq("fdrop_pulse", {31'd0, drop_pulse}, 32'd1);
        check_eq("fdrop_count", {29'd0, count}, 32'd4);
        check_eq("fdrop_head",  {16'd0, out_data}, 32'h0000A000);
`ifdef INGRESS_DROP_CNT_EN
        check_eq("fdrop_cnt",   {24'd0, drop_cnt}, 32'd1);
`endif
        drive(1'b0, 4'b0000, 4'b0000, 16'h0000, 1'b0);
        tick();
        check_eq("fdrop_pulse_end", {31'd0, drop_pulse}, 32'd0);

        // full + simultaneous pop: accepted, count stays 4
        drive(1'b1, 4'b0001, 4'b0100, 16'hBEEF, 1'b1);
        tick();
        check_eq("fpop_count", {29'd0, count}, 32'd4);
        check_eq("fpop_pulse", {31'd0, drop_pulse}, 32'd0);
        check_eq("fpop_head",  {16'd0, out_data}, 32'h0000A001);

        // drain remaining: A001..A003 already checked head A001, then BEEF last
        drive(1'b0, 4'b0000, 4'b0000, 16'h0000, 1'b1);
        tick();
        check_eq("drain_a002", {16'd0, out_data}, 32'h0000A002);
        tick();
        check_eq("drain_a003", {16'd0, out_data}, 32'h0000A003);
        check_eq("drain_tgt3", {28'd0, out_target}, 32'd2);
        tick();
        check_eq("drain_beef", {16'd0, out_data}, 32'h0000BEEF);
        check_eq("drain_tgtb", {28'd0, out_target}, 32'd4);
        tick();
        check_eq("drain_empty", {31'd0, empty}, 32'd1);
        check_eq("drain_count", {29'd0, count}, 32'd0);
        check_eq("drain_data0", {16'd0, out_data}, 32'd0);
        // out_ready while empty is ignored
        tick();
        check_eq("empty_rdy_count", {29'd0, count}, 32'd0);

        // ---------------- illegal packets ----------------
        drive(1'b1, 4'b0011, 4'b0100, 16'h1111, 1'b0);
        tick();
        check_eq("ill_two_src_pulse", {31'd0, drop_pulse}, 32'd1);
        drive(1'b1, 4'b0001, 4'b0000, 16'h2222, 1'b0);
        tick();
        check_eq("ill_zero_tgt_pulse", {31'd0, drop_pulse}, 32'd1);
        drive(1'b1, 4'b0100, 4'b0100, 16'h3333, 1'b0);
        tick();
        check_eq("ill_same_pulse", {31'd0, drop_pulse}, 32'd1);
        check_eq("ill_empty",      {31'd0, empty}, 32'd1);
        check_eq("ill_out_valid",  {31'd0, out_valid}, 32'd0);
`ifdef INGRESS_DROP_CNT_EN
        // one earlier full drop plus these three
        check_eq("ill_drop_cnt",   {24'd0, drop_cnt}, 32'd4);
`endif
        drive(1'b0, 4'b0000, 4'b0000, 16'h0000, 1'b0);
        tick();

        // ---------------- wrap-around ----------------
        model_cnt = 0;
        pushed    = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (pushed == 10 && model_cnt == 0) break;
            do_push = 1'b0;
            do_pop  = 1'b0;
            if (model_cnt == 0) begin
                do_push = (pushed < 10);
            end else if (model_cnt == 1) begin
                do_push = (pushed < 10);
                do_pop  = !((pushed % 3) == 2) || (pushed >= 10);
            end else begin
                do_pop  = 1'b1;
            end
            if (do_pop) begin
                check_eq("wrap_head_data", {16'd0, out_data}, {16'd0, exp_q[0]});
                check_eq("wrap_head_tgt",  {28'd0, out_target}, {28'd0, exp_t_q[0]});
            end
            drive(do_push, 4'b0001, tgt_tab[pushed % 3], 16'hC000 + 16'(pushed), do_pop);
            tick();
            if (do_pop) begin
                void'(exp_q.pop_front());
                void'(exp_t_q.pop_front());
                model_cnt--;
            end
            if (do_push) begin
                exp_q.push_back(16'hC000 + 16'(pushed));
                exp_t_q.push_back(tgt_tab[pushed % 3]);
                pushed++;
                model_cnt++;
            end
            check_eq("wrap_count", {29'd0, count}, model_cnt);
        end
        check_eq("wrap_all_pushed", pushed, 32'd10);
        check_eq("wrap_empty", {31'd0, empty}, 32'd1);
        drive(1'b0, 4'b0000, 4'b0000, 16'h0000, 1'b0);
        tick();

        // ---------------- saturation ----------------
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 4'b0011, 4'b0100, 16'h5555, 1'b0);
            tick();
            if (drop_pulse === 1'b1) pulses++;
        end
        drive(1'b0, 4'b0000, 4'b0000, 16'h0000, 1'b0);
        tick();
        check_eq("sat_pulses", pulses, 32'd300);
        check_eq("sat_pulse_end", {31'd0, drop_pulse}, 32'd0);
        check_eq("sat_empty", {31'd0, empty}, 32'd1);
`ifdef INGRESS_DROP_CNT_EN
        check_eq("sat_drop_cnt", {24'd0, drop_cnt}, 32'd255);
        drive(1'b1, 4'b0000, 4'b0100, 16'h5555, 1'b0);
        tick();
        drive(1'b0, 4'b0000, 4'b0000, 16'h0000, 1'b0);
        tick();
        check_eq("sat_drop_hold", {24'd0, drop_cnt}, 32'd255);
`endif

        // ---------------- mid-operation reset ----------------
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'b0010, 4'b1000, 16'hD000 + 16'(i), 1'b0);
            tick();
        end
        check_eq("mrst_pre_count", {29'd0, count}, 32'd3);
        // push and pop requested in the reset cycle; reset wins
        rst = 1'b1;
        drive(1'b1, 4'b0010, 4'b0001, 16'hE000, 1'b1);
        tick();
        rst = 1'b0;
        drive(1'b0, 4'b0000, 4'b0000, 16'h0000, 1'b0);
        check_eq("mrst_count",     {29'd0, count}, 32'd0);
        check_eq("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mrst_out_data",  {16'd0, out_data}, 32'd0);
        check_eq("mrst_empty",     {31'd0, empty}, 32'd1);
        check_eq("mrst_pulse",     {31'd0, drop_pulse}, 32'd0);
`ifdef INGRESS_DROP_CNT_EN
        check_eq("mrst_drop_cnt",  {24'd0, drop_cnt}, 32'd0);
`endif
        tick();
        check_eq("mrst_no_store", {29'd0, count}, 32'd0);
        drive(1'b1, 4'b1000, 4'b0001, 16'hF000, 1'b0);
        tick();
        check_eq("post_rst_head", {16'd0, out_data}, 32'h0000F000);
        check_eq("post_rst_src",  {28'd0, out_source}, 32'd8);
        check_eq("post_rst_count", {29'd0, count}, 32'd1);
        drive(1'b0, 4'b0000, 4'b0000, 16'h0000, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
